// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: core-side request/response bundle of the riscv_lsu byte-serial
// load/store sequencer. The core drives through master; the sequencer uses slave.
interface riscv_lsu_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_LENGTH-1:0] addr;
  logic                   write_en;
  logic [WORD_LENGTH-1:0] wdata;
  logic [1:0]             ram_mask_sel;
  logic                   load_unsigned;
  logic                   resp_valid;
  logic [WORD_LENGTH-1:0] rdata;
  logic                   busy;

  modport master (
    output req_valid, addr, write_en, wdata, ram_mask_sel, load_unsigned,
    input  req_ready, resp_valid, rdata, busy
  );

  modport slave (
    input  req_valid, addr, write_en, wdata, ram_mask_sel, load_unsigned,
    output req_ready, resp_valid, rdata, busy
  );
endinterface

// File: rtl/riscv_lsu.sv
// riscv_lsu: turns one byte/half/word core request into 1, 2 or 4 little-endian
// byte accesses on a byte-wide BRAM. Define RISCV_LSU_MISALIGN_TRAP_EN to trap misaligned H/W.
module riscv_lsu #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  riscv_lsu_if.slave             core,
  output logic                   bram_write_en,
  output logic [ADDR_LENGTH-1:0] bram_addr,
  output logic [7:0]             bram_wdata,
  input  logic [7:0]             bram_dout
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  ,
  output logic                   misalign
`endif
);

  localparam logic [1:0] MASK_B = 2'd0;
  localparam logic [1:0] MASK_H = 2'd1;
  localparam logic [1:0] MASK_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DRAIN,
    RESP
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic                   accept;
  logic                   misaligned_req;
  logic                   access_done;
  logic [1:0]             req_last_idx;
  logic [1:0]             last_idx;
  logic [1:0]             byte_cnt;
  logic [1:0]             next_cnt;
  logic [1:0]             prev_cnt;
  logic                   is_store;
  logic                   load_unsigned_q;
  logic [WORD_LENGTH-1:0] wdata_sr;
  logic [WORD_LENGTH-1:0] rdata_q;
  logic [WORD_LENGTH-1:0] load_word;
  logic [3:0][7:0]        load_buf;
  logic [3:0][7:0]        assembled;
  logic [7:0]             fill_byte;

  assign accept      = core.req_valid && (state == IDLE);
  assign access_done = (byte_cnt == last_idx);
  assign next_cnt    = byte_cnt + 2'd1;
  assign prev_cnt    = byte_cnt - 2'd1;

  // Index of the last byte of the access; unknown encodings behave as a word.
  always_comb begin
    req_last_idx = 2'd3;
    case (core.ram_mask_sel)
      MASK_B:  req_last_idx = 2'd0;
      MASK_H:  req_last_idx = 2'd1;
      MASK_W:  req_last_idx = 2'd3;
      default: req_last_idx = 2'd3;
    endcase
  end

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  logic trap_q;

  assign misaligned_req = ((req_last_idx == 2'd1) && core.addr[0]) ||
                          ((req_last_idx == 2'd3) && (core.addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else if (accept) begin
      trap_q <= misaligned_req;
    end
  end

  assign misalign = (state == RESP) && trap_q;
`else
  assign misaligned_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = misaligned_req ? RESP : ACCESS;
      ACCESS:  if (access_done) next_state = is_store ? RESP : DRAIN;
      DRAIN:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The final byte arrives in DRAIN straight from the BRAM, so it bypasses load_buf
  // and also supplies the sign for the upper bytes.
  always_comb begin
    assembled           = load_buf;
    assembled[last_idx] = bram_dout;
    fill_byte           = load_unsigned_q ? 8'h00 : {8{bram_dout[7]}};
    for (int k = 0; k < 4; k++) begin
      if (k > int'(last_idx)) assembled[k] = fill_byte;
    end
    load_word = assembled;
  end

  // BRAM outputs are registered so reset clears them immediately; each ACCESS
  // cycle already presents the address/byte prepared on the previous edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bram_write_en   <= 1'b0;
      bram_addr       <= '0;
      bram_wdata      <= '0;
      byte_cnt        <= '0;
      last_idx        <= '0;
      is_store        <= 1'b0;
      load_unsigned_q <= 1'b0;
      wdata_sr        <= '0;
      load_buf        <= '0;
      rdata_q         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            is_store        <= core.write_en;
            load_unsigned_q <= core.load_unsigned;
            last_idx        <= req_last_idx;
            byte_cnt        <= '0;
            wdata_sr        <= core.wdata >> 8;
            if (!misaligned_req) begin
              bram_addr     <= core.addr;
              bram_wdata    <= core.wdata[7:0];
              bram_write_en <= core.write_en;
            end
          end
        end
        ACCESS: begin
          if (!is_store && (byte_cnt != 2'd0)) begin
            load_buf[prev_cnt] <= bram_dout;
          end
          if (access_done) begin
            bram_write_en <= 1'b0;
          end else begin
            byte_cnt   <= next_cnt;
            bram_addr  <= bram_addr + ADDR_LENGTH'(1);
            bram_wdata <= wdata_sr[7:0];
            wdata_sr   <= wdata_sr >> 8;
          end
        end
        DRAIN: begin
          rdata_q <= load_word;
        end
        RESP: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign core.req_ready  = (state == IDLE);
  assign core.busy       = (state != IDLE);
  assign core.resp_valid = (state == RESP);
  assign core.rdata      = rdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed and random requests against riscv_lsu with a byte-array
// BRAM and a flat reference memory; honours RISCV_LSU_MISALIGN_TRAP_EN.
module tb_riscv_lsu;

  localparam logic [1:0] MASK_B = 2'd0;
  localparam logic [1:0] MASK_H = 2'd1;
  localparam logic [1:0] MASK_W = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        bram_write_en;
  logic [31:0] bram_addr;
  logic [7:0]  bram_wdata;
  logic [7:0]  bram_dout;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  bit [7:0]    mem     [0:4095];
  bit [7:0]    ref_mem [0:4095];
  logic [31:0] exp_rdata;
  int          total_checks;
  int          pass_checks;
  int          fail_checks;

  riscv_lsu_if #(.WORD_LENGTH(32), .ADDR_LENGTH(32)) bus ();

  riscv_lsu #(.WORD_LENGTH(32), .ADDR_LENGTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .core          (bus),
    .bram_write_en (bram_write_en),
    .bram_addr     (bram_addr),
    .bram_wdata    (bram_wdata),
    .bram_dout     (bram_dout)
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    ,
    .misalign      (misalign)
`endif
  );

  always #5 clk = ~clk;

  // Byte-wide synchronous BRAM, aliased on the low 12 address bits.
  always @(posedge clk) begin
    if (bram_write_en) mem[bram_addr[11:0]] <= bram_wdata;
    bram_dout <= mem[bram_addr[11:0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) pass_checks++;
    else begin
      fail_checks++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int sizeOf(input logic [1:0] sel);
    return (sel == MASK_B) ? 1 : ((sel == MASK_H) ? 2 : 4);
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input int n, input logic uns);
    logic [31:0] v;
    logic [31:0] ad;
    logic [7:0]  top;
    v = 32'h0;
    top = 8'h00;
    for (int i = 0; i < n; i++) begin
      ad  = a + 32'(i);
      top = ref_mem[ad[11:0]];
      v   = v + (32'(top) << (8 * i));
    end
    if (!uns && top[7] && (n < 4)) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [1:0] sel, input logic uns,
                               output logic [31:0] obs_rdata);
    int          n;
    bit          trap;
    int          exp_lat;
    int          lat;
    int          wr_cnt;
    int          wr_bad;
    bit          ready_bad;
    logic [31:0] wa;
    logic [7:0]  wb;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    logic        mis_seen;
    mis_seen = 1'b0;
`endif
    n    = sizeOf(sel);
    trap = 1'b0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    trap = ((n == 2) && a[0]) || ((n == 4) && (a[1:0] != 2'b00));
`endif
    exp_lat = trap ? 1 : (we ? n + 1 : n + 2);
    if (!we && !trap) exp_rdata = refLoad(a, n, uns);

    @(negedge clk);
    checkOutput({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid     = 1'b1;
    bus.write_en      = we;
    bus.addr          = a;
    bus.wdata         = wd;
    bus.ram_mask_sel  = sel;
    bus.load_unsigned = uns;
    @(posedge clk);
    #1;
    bus.req_valid     = 1'b0;
    bus.write_en      = 1'($urandom);
    bus.addr          = $urandom;
    bus.wdata         = $urandom;
    bus.ram_mask_sel  = 2'($urandom);
    bus.load_unsigned = 1'($urandom);

    lat = 0; wr_cnt = 0; wr_bad = 0; ready_bad = 1'b0; obs_rdata = 32'hx;
    for (int k = 1; (k <= 12) && (lat == 0); k++) begin
      @(negedge clk);
      if (bus.req_ready || !bus.busy) ready_bad = 1'b1;
      if (bram_write_en) begin
        wa = a + 32'(wr_cnt);
        wb = 8'(wd >> (8 * wr_cnt));
        if (!we || trap || (wr_cnt >= n) || (bram_addr !== wa) || (bram_wdata !== wb)) wr_bad++;
        wr_cnt++;
      end
      if (bus.resp_valid) begin
        lat       = k;
        obs_rdata = bus.rdata;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        mis_seen  = misalign;
`endif
      end
    end

    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_wcnt"}, 32'(wr_cnt), (we && !trap) ? 32'(n) : 32'd0);
    checkOutput({tag, "_wbad"}, 32'(wr_bad), 32'd0);
    checkOutput({tag, "_busy"}, 32'(ready_bad), 32'd0);
    checkOutput({tag, "_rdata"}, obs_rdata, exp_rdata);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    checkOutput({tag, "_mis"}, 32'(mis_seen), 32'(trap));
`endif

    if (we && !trap) begin
      for (int i = 0; i < n; i++) begin
        wa = a + 32'(i);
        ref_mem[wa[11:0]] = 8'(wd >> (8 * i));
      end
    end

    @(negedge clk);
    checkOutput({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
    checkOutput({tag, "_idle"}, 32'(bus.req_ready), 32'd1);
  endtask

  // Two byte loads with req_valid held high across the first transaction.
  task automatic runBackToBack();
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] r1d;
    logic [31:0] r2d;
    int          acc_k;
    int          resp_n;
    int          r1k;
    int          r2k;
    bit          ready_bad;
    exp1 = refLoad(32'h100, 1, 1'b1);
    exp2 = refLoad(32'h103, 1, 1'b1);
    acc_k = 0; resp_n = 0; r1k = 0; r2k = 0; ready_bad = 1'b0;
    r1d = 32'h0; r2d = 32'h0;
    @(negedge clk);
    bus.req_valid     = 1'b1;
    bus.write_en      = 1'b0;
    bus.ram_mask_sel  = MASK_B;
    bus.load_unsigned = 1'b1;
    bus.addr          = 32'h100;
    @(posedge clk);
    #1;
    bus.addr = 32'h103;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        resp_n++;
        if (resp_n == 1) begin r1k = k; r1d = bus.rdata; end
        else begin r2k = k; r2d = bus.rdata; end
      end
      if ((k <= 3) && bus.req_ready) ready_bad = 1'b1;
      if ((acc_k == 0) && bus.req_ready && bus.req_valid) begin
        acc_k = k;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
      end
    end
    checkOutput("b2b_accept_cycle", 32'(acc_k), 32'd4);
    checkOutput("b2b_ready_low", 32'(ready_bad), 32'd0);
    checkOutput("b2b_resp_count", 32'(resp_n), 32'd2);
    checkOutput("b2b_resp1_cycle", 32'(r1k), 32'd3);
    checkOutput("b2b_resp2_cycle", 32'(r2k), 32'd7);
    checkOutput("b2b_rdata1", r1d, exp1);
    checkOutput("b2b_rdata2", r2d, exp2);
    exp_rdata = exp2;
  endtask

  // Reset in the second byte of a word store: only byte 0 may reach the BRAM.
  task automatic runResetAbort();
    bit resp_seen;
    resp_seen = 1'b0;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.write_en     = 1'b1;
    bus.addr         = 32'h180;
    bus.wdata        = 32'h1122_3344;
    bus.ram_mask_sel = MASK_W;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_pre_we", 32'(bram_write_en), 32'd1);
    checkOutput("rst_pre_addr", bram_addr, 32'h181);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_we", 32'(bram_write_en), 32'd0);
    checkOutput("rst_async_addr", bram_addr, 32'h0);
    checkOutput("rst_async_rdata", bus.rdata, 32'h0);
    checkOutput("rst_async_busy", 32'(bus.busy), 32'd0);
    ref_mem[12'h180] = 8'h44;
    exp_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.resp_valid) resp_seen = 1'b1;
    end
    checkOutput("rst_no_resp", 32'(resp_seen), 32'd0);
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] obs;
    logic        r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_sel;
    total_checks = 0;
    pass_checks  = 0;
    fail_checks  = 0;
    exp_rdata    = 32'h0;
    reset             = 1'b1;
    bus.req_valid     = 1'b0;
    bus.addr          = 32'h0;
    bus.write_en      = 1'b0;
    bus.wdata         = 32'h0;
    bus.ram_mask_sel  = MASK_W;
    bus.load_unsigned = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset_resp", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_rdata", bus.rdata, 32'h0);
    checkOutput("reset_bram_we", 32'(bram_write_en), 32'd0);
    checkOutput("reset_bram_addr", bram_addr, 32'h0);
    checkOutput("reset_bram_wdata", 32'(bram_wdata), 32'd0);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    checkOutput("reset_misalign", 32'(misalign), 32'd0);
`endif
    reset = 1'b0;

    applyStimulus("st_w100", 1'b1, 32'h100, 32'hDEAD_BEEF, MASK_W, 1'b0, obs);
    applyStimulus("ld_w100", 1'b0, 32'h100, 32'h0, MASK_W, 1'b0, obs);
    checkOutput("ld_w100_value", obs, 32'hDEAD_BEEF);
    applyStimulus("ld_b103s", 1'b0, 32'h103, 32'h0, MASK_B, 1'b0, obs);
    checkOutput("ld_b103s_value", obs, 32'hFFFF_FFDE);
    applyStimulus("ld_b103u", 1'b0, 32'h103, 32'h0, MASK_B, 1'b1, obs);
    checkOutput("ld_b103u_value", obs, 32'h0000_00DE);

    applyStimulus("st_b203", 1'b1, 32'h203, 32'h0000_005A, MASK_B, 1'b0, obs);
    applyStimulus("st_h201", 1'b1, 32'h201, 32'h0000_1234, MASK_H, 1'b0, obs);
    applyStimulus("ld_h201", 1'b0, 32'h201, 32'h0, MASK_H, 1'b0, obs);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    checkOutput("ld_h201_value", obs, 32'h0000_00DE);
`else
    checkOutput("ld_h201_value", obs, 32'h0000_1234);
`endif
    applyStimulus("ld_b203", 1'b0, 32'h203, 32'h0, MASK_B, 1'b1, obs);
    checkOutput("ld_b203_value", obs, 32'h0000_005A);

    runBackToBack();

    applyStimulus("st_wrap", 1'b1, 32'hFFFF_FFFE, 32'hA1B2_C3D4, MASK_W, 1'b0, obs);
    applyStimulus("ld_wrap", 1'b0, 32'hFFFF_FFFE, 32'h0, MASK_W, 1'b0, obs);
`ifndef RISCV_LSU_MISALIGN_TRAP_EN
    checkOutput("ld_wrap_value", obs, 32'hA1B2_C3D4);
`endif

    runResetAbort();
    applyStimulus("ld_w180", 1'b0, 32'h180, 32'h0, MASK_W, 1'b0, obs);
    checkOutput("ld_w180_value", obs, 32'h0000_0044);

    for (int t = 0; t < 40; t++) begin
      r_we   = 1'($urandom);
      r_sel  = 2'($urandom_range(0, 3));
      r_addr = 32'h300 + 32'($urandom_range(0, 63));
      applyStimulus($sformatf("rnd%0d", t), r_we, r_addr, $urandom, r_sel, 1'($urandom), obs);
    end

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store sequencer that sits directly upstream of the byte-wide block RAM in the data path. It accepts one word/half/byte request from the core over a valid/ready handshake and issues 1, 2 or 4 byte-serial BRAM accesses at consecutive addresses in little-endian order. For loads it assembles the returned bytes, sign- or zero-extends the result, and returns it with a one-cycle response pulse. It replaces the free-running fixed-length byte sequencer with a request-driven one.

Parameters:
WORD_LENGTH, 32, data word width (fixed 32; bytes 0..3)
ADDR_LENGTH, 32, byte address width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  core presents a request
req_ready  output  1  block can accept; high only in IDLE
addr  input  ADDR_LENGTH  byte base address
write_en  input  1  1 = store, 0 = load
wdata  input  WORD_LENGTH  store data, byte 0 = wdata[7:0]
ram_mask_sel  input  MASK_SEL  MASK_B / MASK_H / MASK_W access size
load_unsigned  input  1  1 = zero-extend load, 0 = sign-extend
resp_valid  output  1  one-cycle completion pulse, loads and stores
rdata  output  WORD_LENGTH  extended load data, held until next load response
busy  output  1  high in any state other than IDLE
bram_write_en  output  1  byte write strobe to BRAM
bram_addr  output  ADDR_LENGTH  BRAM byte address (read and write)
bram_wdata  output  8  BRAM write byte
bram_dout  input  8  BRAM read byte; valid the cycle after its address is presented

Behaviour:
- Reset (async, active-high): state=IDLE, req_ready=1, resp_valid=0, busy=0, rdata=0, bram_write_en=0, bram_addr=0, bram_wdata=0, byte counter=0. BRAM outputs are forced inactive immediately on reset assertion, without waiting for a clock edge.
- N = 1 for MASK_B, 2 for MASK_H, 4 for MASK_W. Any other encoding is treated as MASK_W.
- Accept: on a rising edge with req_valid && req_ready, latch addr, write_en, wdata, N and load_unsigned. Inputs are ignored while busy.
- States: IDLE -> ACCESS (on accept) -> DRAIN (loads only) -> RESP -> IDLE.
- ACCESS lasts exactly N cycles, with index i = 0..N-1:
  - bram_addr = base + i, with modulo-2^ADDR_LENGTH wrap; no alignment requirement.
  - Stores: bram_write_en=1 and bram_wdata = latched wdata[8i+7:8i].
  - Loads: bram_write_en=0. In ACCESS cycle i >= 1, capture bram_dout into byte i-1.
- DRAIN (loads only, 1 cycle): capture bram_dout into byte N-1, with bram_write_en=0.
- RESP (1 cycle): resp_valid=1.
  - Loads: rdata is updated at the same edge that enters RESP. Bytes N..3 are filled with the sign of byte N-1, or with 0 when load_unsigned=1.
  - Stores: rdata is unchanged.
- Latency, counting the first ACCESS cycle as cycle 1 after the accepting edge:
  - Load: resp_valid in cycle N+2.
  - Store: resp_valid in cycle N+1.
  - A new request can be accepted on the edge ending RESP+1, i.e. the first IDLE cycle. There is no accept during RESP.
- Outside ACCESS, bram_write_en=0; bram_addr and bram_wdata hold their last values.
- Reset mid-operation aborts the access. Bytes already written stay written, no response is produced, and rdata returns to 0.

Optional Feature:
RISCV_LSU_MISALIGN_TRAP_EN
- Defined:
  - Adds output port misalign (1 bit, reset 0).
  - A request with MASK_H and addr[0]=1, or MASK_W and addr[1:0]!=0, issues no BRAM access and goes IDLE -> RESP directly.
  - In that RESP cycle, resp_valid=1 and misalign=1; rdata is unchanged.
  - misalign=0 on all other responses.
- Undefined: no misalign port; every alignment proceeds byte-serially as above.

Test Plan:
- Store word 0xDEADBEEF @0x100, then load MASK_W @0x100 -> BRAM 0x100..0x103 = EF,BE,AD,DE; store resp_valid in cycle 5; load resp_valid in cycle 6 with rdata=0xDEADBEEF.
- Load MASK_B @0x103, load_unsigned=0 -> rdata=0xFFFFFFDE; repeat with load_unsigned=1 -> rdata=0x000000DE; each resp_valid in cycle 3.
- Store MASK_H 0x00001234 @0x201, then load MASK_H signed @0x201 -> writes only 0x201=34 and 0x202=12, 0x203 untouched; rdata=0x00001234. With the macro defined -> misalign=1, no BRAM writes.
- req_valid held high for back-to-back byte loads -> req_ready low for ACCESS/DRAIN/RESP; second request accepted on the first IDLE edge; exactly one resp_valid per request.
- Word store @0xFFFFFFFE -> bram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001 (wrap).
- Assert reset during ACCESS i=1 of a word store -> bram_write_en drops asynchronously; no resp_valid; rdata=0; req_ready=1 after reset release.
